// File: rtl/adbg_wb_arbiter_if.sv
// ------------------------------------------------------------------
// adbg_wb_arbiter_if: Wishbone port bundle for the debug bus arbiter.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

interface adbg_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   wdat;
  logic [DATA_WIDTH/8-1:0] sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic [DATA_WIDTH-1:0]   rdat;
  logic                    ack;
  logic                    err;

  modport master (
    output cyc, stb, we, adr, wdat, sel, cti, bte,
    input  rdat, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, wdat, sel, cti, bte,
    output rdat, ack, err
  );
endinterface

`default_nettype wire

// File: rtl/adbg_wb_arbiter.sv
// ------------------------------------------------------------------
// adbg_wb_arbiter: two-master Wishbone arbiter with fair tie-break and
// bus watchdog.  Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module adbg_wb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  adbg_wb_arbiter_if.slave       m0,
  adbg_wb_arbiter_if.slave       m1,
  adbg_wb_arbiter_if.master      s,
  output logic [1:0]             gnt_o,
  output logic                   timeout_o
);

  // State encoding doubles as the one-hot grant vector.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_m1;
  logic       last_m1_nxt;
  logic       fire;

  always_comb begin
    state_nxt   = state;
    last_m1_nxt = last_m1;
    case (state)
      IDLE: begin
        if (m0.cyc && m1.cyc) state_nxt = last_m1 ? GNT0 : GNT1;
        else if (m0.cyc)      state_nxt = GNT0;
        else if (m1.cyc)      state_nxt = GNT1;
      end
      GNT0: begin
        if (!m0.cyc) begin
          state_nxt   = IDLE;
          last_m1_nxt = 1'b0;
        end
      end
      GNT1: begin
        if (!m1.cyc) begin
          state_nxt   = IDLE;
          last_m1_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= IDLE;
      last_m1 <= 1'b1;
    end else begin
      state   <= state_nxt;
      last_m1 <= last_m1_nxt;
    end
  end

  assign gnt_o = state;

  logic                    cyc_mux;
  logic                    stb_mux;
  logic                    we_mux;
  logic [ADDR_WIDTH-1:0]   adr_mux;
  logic [DATA_WIDTH-1:0]   dat_mux;
  logic [DATA_WIDTH/8-1:0] sel_mux;
  logic [2:0]              cti_mux;
  logic [1:0]              bte_mux;

  always_comb begin
    cyc_mux = 1'b0;
    stb_mux = 1'b0;
    we_mux  = 1'b0;
    adr_mux = '0;
    dat_mux = '0;
    sel_mux = '0;
    cti_mux = '0;
    bte_mux = '0;
    case (state)
      GNT0: begin
        cyc_mux = m0.cyc;
        stb_mux = m0.stb;
        we_mux  = m0.we;
        adr_mux = m0.adr;
        dat_mux = m0.wdat;
        sel_mux = m0.sel;
        cti_mux = m0.cti;
        bte_mux = m0.bte;
      end
      GNT1: begin
        cyc_mux = m1.cyc;
        stb_mux = m1.stb;
        we_mux  = m1.we;
        adr_mux = m1.adr;
        dat_mux = m1.wdat;
        sel_mux = m1.sel;
        cti_mux = m1.cti;
        bte_mux = m1.bte;
      end
      default: ;
    endcase
  end

  assign s.cyc  = cyc_mux;
  assign s.stb  = stb_mux;
  assign s.we   = we_mux;
  assign s.adr  = adr_mux;
  assign s.wdat = dat_mux;
  assign s.sel  = sel_mux;
  assign s.cti  = cti_mux;
  assign s.bte  = bte_mux;

  assign m0.rdat = s.rdat;
  assign m1.rdat = s.rdat;
  assign m0.ack  = s.ack & state[0];
  assign m1.ack  = s.ack & state[1];
  assign m0.err  = (s.err | fire) & state[0];
  assign m1.err  = (s.err | fire) & state[1];

  generate
    if (TIMEOUT > 0) begin : g_wdt
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt;

      // Any slave response wins over the watchdog in the same cycle.
      assign fire = s.stb && !s.ack && !s.err && (cnt == CW'(TIMEOUT));

      always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)                               cnt <= '0;
        else if (!s.stb || s.ack || s.err || fire)    cnt <= '0;
        else                                          cnt <= cnt + 1'b1;
      end
    end else begin : g_no_wdt
      assign fire = 1'b0;
    end
  endgenerate

  assign timeout_o = fire;

endmodule

`default_nettype wire

// File: tb/tb_adbg_wb_arbiter.sv
// ------------------------------------------------------------------
// tb_adbg_wb_arbiter: directed self-checking bench for adbg_wb_arbiter.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_adbg_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] gnt;
  logic       tmo;
  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_gnt;

  adbg_wb_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
  adbg_wb_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
  adbg_wb_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

  adbg_wb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .m0        (m0_if.slave),
    .m1        (m1_if.slave),
    .s         (s_if.master),
    .gnt_o     (gnt),
    .timeout_o (tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b0; m0_if.adr = '0;
    m0_if.wdat = '0;  m0_if.sel = 4'hf; m0_if.cti = '0;  m0_if.bte = '0;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0; m1_if.adr = '0;
    m1_if.wdat = '0;  m1_if.sel = 4'hf; m1_if.cti = '0;  m1_if.bte = '0;
    s_if.rdat = '0;   s_if.ack = 1'b1;  s_if.err = 1'b0;

    // Reset holds everything quiet even with a master requesting and ack high
    repeat (2) tick();
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_s_cyc", 64'(s_if.cyc), 64'd0);
    check("rst_s_stb", 64'(s_if.stb), 64'd0);
    check("rst_m0_ack", 64'(m0_if.ack), 64'd0);
    check("rst_timeout", 64'(tmo), 64'd0);
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; s_if.ack = 1'b0;
    tick();
    rst_n = 1'b1;

    // Simultaneous request after reset: m0 wins the first tie
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b1;
    m0_if.adr = 32'h100; m0_if.wdat = 32'hcafe0001;
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h200;
    #1;
    check("tie_no_grant_yet", 64'(gnt), 64'd0);
    tick();
    check("tie_gnt_m0", 64'(gnt), 64'h1);
    check("tie_s_adr", 64'(s_if.adr), 64'h100);
    check("tie_s_we", 64'(s_if.we), 64'd1);
    check("tie_s_wdat", 64'(s_if.wdat), 64'hcafe0001);
    s_if.ack = 1'b1; s_if.rdat = 32'hdeadbeef;
    #1;
    check("tie_m0_ack", 64'(m0_if.ack), 64'd1);
    check("tie_m1_ack", 64'(m1_if.ack), 64'd0);
    check("tie_m1_rdat", 64'(m1_if.rdat), 64'hdeadbeef);
    tick();
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0; s_if.ack = 1'b0;
    #1;
    check("drop_s_cyc", 64'(s_if.cyc), 64'd0);
    tick();
    check("idle_gap", 64'(gnt), 64'd0);
    tick();
    check("gnt_m1", 64'(gnt), 64'h2);
    check("m1_s_adr", 64'(s_if.adr), 64'h200);
    s_if.ack = 1'b1;
    #1;
    check("m1_ack", 64'(m1_if.ack), 64'd1);
    check("m1_m0_ack", 64'(m0_if.ack), 64'd0);
    tick();
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; s_if.ack = 1'b0;
    tick();

    // 8-beat incrementing burst from m0 is never split by m1
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.cti = 3'b010; m0_if.adr = 32'h1000;
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h2000;
    tick();
    for (int i = 0; i < 8; i++) begin
      m0_if.cti = (i == 7) ? 3'b111 : 3'b010;
      m0_if.adr = 32'h1000 + 32'(4 * i);
      s_if.ack  = 1'b1;
      #1;
      check("burst_gnt", 64'(gnt), 64'h1);
      check("burst_m0_ack", 64'(m0_if.ack), 64'd1);
      check("burst_m1_ack", 64'(m1_if.ack), 64'd0);
      check("burst_s_adr", 64'(s_if.adr), 64'h1000 + 64'(4 * i));
      tick();
    end
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.cti = '0; s_if.ack = 1'b0;
    tick();
    check("burst_idle", 64'(gnt), 64'd0);
    tick();
    check("after_burst_gnt_m1", 64'(gnt), 64'h2);

    // Unanswered m1 read: watchdog fires in the fifth cycle with stb high
    #1;
    check("wd_c0", 64'(tmo), 64'd0);
    for (int j = 1; j < 4; j++) begin
      tick();
      check("wd_quiet", 64'(tmo), 64'd0);
      check("wd_quiet_m1_err", 64'(m1_if.err), 64'd0);
    end
    tick();
    check("wd_fire", 64'(tmo), 64'd1);
    check("wd_m1_err", 64'(m1_if.err), 64'd1);
    check("wd_m0_err", 64'(m0_if.err), 64'd0);
    tick();
    check("wd_one_shot", 64'(tmo), 64'd0);
    check("wd_m1_err_clr", 64'(m1_if.err), 64'd0);
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    tick();

    // Asynchronous reset in the middle of an m1 transfer
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h3000;
    tick();
    check("pre_rst_gnt", 64'(gnt), 64'h2);
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h4000;
    s_if.ack = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 64'(gnt), 64'd0);
    check("arst_s_cyc", 64'(s_if.cyc), 64'd0);
    check("arst_s_stb", 64'(s_if.stb), 64'd0);
    check("arst_m1_ack", 64'(m1_if.ack), 64'd0);
    s_if.ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_gnt_m0", 64'(gnt), 64'h1);
    check("post_rst_s_adr", 64'(s_if.adr), 64'h4000);
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    tick();
    check("post_rst_idle", 64'(gnt), 64'd0);

    // Back-to-back requests from both masters alternate strictly
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
    exp_gnt = 2'b10;
    for (int t = 0; t < 10; t++) begin
      m0_if.adr = 32'h5000 + 32'(t);
      m1_if.adr = 32'h6000 + 32'(t);
      tick();
      check("alt_gnt", 64'(gnt), 64'(exp_gnt));
      check("alt_s_adr", 64'(s_if.adr),
            exp_gnt[0] ? 64'h5000 + 64'(t) : 64'h6000 + 64'(t));
      s_if.ack = 1'b1;
      #1;
      check("alt_owner_ack", 64'(exp_gnt[0] ? m0_if.ack : m1_if.ack), 64'd1);
      check("alt_other_ack", 64'(exp_gnt[0] ? m1_if.ack : m0_if.ack), 64'd0);
      tick();
      s_if.ack = 1'b0;
      if (exp_gnt[0]) begin m0_if.cyc = 1'b0; m0_if.stb = 1'b0; end
      else            begin m1_if.cyc = 1'b0; m1_if.stb = 1'b0; end
      tick();
      check("alt_idle", 64'(gnt), 64'd0);
      if (exp_gnt[0]) begin m0_if.cyc = 1'b1; m0_if.stb = 1'b1; end
      else            begin m1_if.cyc = 1'b1; m1_if.stb = 1'b1; end
      exp_gnt = {exp_gnt[0], exp_gnt[1]};
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
